cla_word_serial_adder: RTL and testbench
========================================

# cla_word_serial_adder

Word-serial wide adder controller. It accepts two N-bit operands over a valid/ready handshake and sequences one W-bit carry-lookahead slice across WORDS cycles. The carry between cycles is held in a register. The result is presented on a valid/ready output port. It sits between the operand source and the result consumer in the arithmetic datapath, so wide additions can share one CLA slice instead of instantiating a full N-bit CLA.

## Interface
- W, 8, width of the CLA slice in bits (≥1)
- WORDS, 4, slices per operand (≥1); N = W*WORDS
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  N  operand A
- b  in  N  operand B
- cin  in  1  carry into slice 0
- out_valid  out  1  sum/cout valid
- out_ready  in  1  consumer accepts result
- sum  out  N  result, registered
- cout  out  1  carry out of the last slice, registered
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b into operand registers; carry_reg<=cin; idx<=0; sum<=0; go to RUN.
- RUN
  - Each cycle the slice computes a_reg[idx*W+:W] + b_reg[idx*W+:W] + carry_reg.
  - sum[idx*W+:W] <= slice sum; carry_reg <= slice carry-out; idx<=idx+1.
  - When idx==WORDS-1: cout <= slice carry-out, go to DONE.
- DONE
  - out_valid=1.
  - On out_ready: go to IDLE.
- in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are decoded from state.
- Operands are never taken outside IDLE; in_valid is ignored in RUN and DONE.
- sum and cout hold stable while out_valid=1 and out_ready=0.
- idx width is max(1, $clog2(WORDS)). idx never exceeds WORDS-1 and does not wrap within one operation.
- Arithmetic is unsigned modulo 2^N. The carry out of bit N-1 appears only on cout; there is no separate overflow flag.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry_reg=0, idx=0.
- Reset asserted in any state aborts the operation immediately. The partial sum is cleared and no out_valid is produced for the aborted operation.
- Latency: input handshake at edge 0; out_valid rises after edge WORDS.
- Output handshake occurs at edge WORDS+1; the next input can be accepted at edge WORDS+2.
- Maximum throughput is one addition per WORDS+2 cycles.
- in_ready=0 from the accept edge until the output handshake completes. No overlap between operations.
- WORDS=1: a single RUN cycle, out_valid after edge 1.
- Combinational depth per cycle is one W-bit CLA slice plus the operand/sum slice multiplexing.

## Structure
- Package cla_pkg:
  - state enum {IDLE, RUN, DONE}
  - default W and WORDS localparams
  - idx-width function
- Sub-module cla_slice: combinational W-bit carry-lookahead adder (a, b, ci -> s, co), built from per-bit generate/propagate carry cells.
- The controller (FSM, idx counter, carry register, operand and sum registers) stays in this module.

## Test plan
All scenarios use W=8, WORDS=4 unless stated otherwise.
- a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, out_valid exactly 4 cycles after accept.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1; the carry propagates through all four slices.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum/cout unchanged, in_ready=0, new operands not captured.
- Assert rst for 1 cycle mid-RUN (2 cycles after accept) -> out_valid=0, in_ready=1, sum=0 immediately. A following add 0x12345678+0x11111111, cin=0 -> sum=0x23456789, cout=0.
- in_valid and out_ready held high, 3 back-to-back operand pairs -> accepts spaced 6 cycles apart, results in order, no results dropped or duplicated.
- W=8, WORDS=1: a=0xF0, b=0x10, cin=0 -> sum=0x00, cout=1, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/cla_word_serial_adder_pkg.sv
// Shared types and helpers for the word-serial carry-lookahead adder.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_WORDS = 4;

    // Word index register width; a single-word adder still keeps a 1-bit index.
    function automatic int idxWidth(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla_word_serial_adder_if.sv
// Operand/result handshake bundle for the word-serial adder.
interface cla_word_serial_adder_if
    import cla_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int WORDS = DEFAULT_WORDS
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W*WORDS-1:0]   a;
    logic [W*WORDS-1:0]   b;
    logic                 cin;
    logic                 out_valid;
    logic                 out_ready;
    logic [W*WORDS-1:0]   sum;
    logic                 cout;
    logic                 busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/cla_word_serial_adder_slice.sv
// Combinational W-bit carry-lookahead slice built from per-bit generate/propagate terms.
module cla_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co
);
    logic [W-1:0] w_gen;
    logic [W-1:0] w_prop;
    logic [W:0]   w_carry;
    logic         w_prefix;

    assign w_gen  = i_a & i_b;
    assign w_prop = i_a ^ i_b;

    // Each carry is the flat lookahead sum of products over all lower generate terms and the slice carry-in.
    always_comb begin
        w_carry    = '0;
        w_prefix   = 1'b1;
        w_carry[0] = i_ci;
        for (int i = 1; i <= W; i++) begin
            w_prefix = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                w_carry[i] = w_carry[i] | (w_prefix & w_gen[j]);
                w_prefix   = w_prefix & w_prop[j];
            end
            w_carry[i] = w_carry[i] | (w_prefix & i_ci);
        end
    end

    assign o_s  = w_prop ^ w_carry[W-1:0];
    assign o_co = w_carry[W];
endmodule

// File: rtl/cla_word_serial_adder.sv
// Word-serial wide adder: one CLA slice reused over WORDS cycles, carry held between cycles.
module cla_word_serial_adder
    import cla_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int WORDS = DEFAULT_WORDS
) (
    input  logic                    clk,
    input  logic                    rst,
    cla_word_serial_adder_if.slave  bus
);
    localparam int N     = W * WORDS;
    localparam int IDX_W = idxWidth(WORDS);

    state_t              r_state;
    logic [N-1:0]        r_a;
    logic [N-1:0]        r_b;
    logic [N-1:0]        r_sum;
    logic                r_carry;
    logic                r_cout;
    logic [IDX_W-1:0]    r_idx;

    logic [W-1:0]        w_sliceA;
    logic [W-1:0]        w_sliceB;
    logic [W-1:0]        w_sliceSum;
    logic                w_sliceCo;
    logic                w_lastWord;

    assign w_sliceA   = r_a[W*r_idx +: W];
    assign w_sliceB   = r_b[W*r_idx +: W];
    assign w_lastWord = (r_idx == IDX_W'(WORDS - 1));

    cla_slice #(.W(W)) u_slice (
        .i_a  (w_sliceA),
        .i_b  (w_sliceB),
        .i_ci (r_carry),
        .o_s  (w_sliceSum),
        .o_co (w_sliceCo)
    );

    // Controller: accept operands in IDLE, walk the slice across the words in RUN, hold the result in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[W*r_idx +: W] <= w_sliceSum;
                    r_carry             <= w_sliceCo;
                    if (w_lastWord) begin
                        r_cout  <= w_sliceCo;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == RUN) || (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_cla_word_serial_adder.sv
// Directed bench for the word-serial CLA adder (4-word and 1-word configurations).
module tb_cla_word_serial_adder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cla_word_serial_adder_if #(.W(8), .WORDS(4)) bus4 ();
    cla_word_serial_adder_if #(.W(8), .WORDS(1)) bus1 ();

    cla_word_serial_adder #(.W(8), .WORDS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    cla_word_serial_adder #(.W(8), .WORDS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Free-running 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair and return just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus4.a        = a;
        bus4.b        = b;
        bus4.cin      = cin;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
    endtask

    // Count edges from the accept until out_valid appears (bounded).
    task automatic waitResult(output int lat);
        lat = 0;
        while (!bus4.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consumeResult();
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus4.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int cyc;
        int nAcc;
        int nRes;
        int accCyc[3];
        logic acc;
        logic hs;
        logic [31:0] sumSnap;
        logic coutSnap;
        logic sawExtra;
        logic [31:0] opA[3];
        logic [31:0] opB[3];
        logic [31:0] expSum[3];
        logic        expCout[3];

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",  {31'd0, bus4.in_ready},  32'd1);
        checkOutput("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        checkOutput("rst_busy",      {31'd0, bus4.busy},      32'd0);
        checkOutput("rst_sum",       bus4.sum,                32'd0);
        checkOutput("rst_cout",      {31'd0, bus4.cout},      32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Carry out of slice 0 into slice 1
        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0);
        checkOutput("t1_in_ready_busy", {30'd0, bus4.in_ready, bus4.busy}, 32'd1);
        waitResult(lat);
        checkOutput("t1_latency", lat,      32'd4);
        checkOutput("t1_sum",     bus4.sum, 32'h0000_0100);
        checkOutput("t1_cout",    {31'd0, bus4.cout}, 32'd0);
        consumeResult();
        checkOutput("t1_after_hs", {30'd0, bus4.in_ready, bus4.out_valid}, 32'd2);

        // Carry rippling through every slice and out
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        waitResult(lat);
        checkOutput("t2_latency", lat,      32'd4);
        checkOutput("t2_sum",     bus4.sum, 32'h0000_0000);
        checkOutput("t2_cout",    {31'd0, bus4.cout}, 32'd1);
        consumeResult();

        // Result held while consumer stalls, new operands ignored
        applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0);
        waitResult(lat);
        checkOutput("t3_latency", lat, 32'd4);
        bus4.a = 32'hAAAA_AAAA; bus4.b = 32'h5555_5555; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("t3_hold_sum", bus4.sum, 32'h0000_0003);
            checkOutput("t3_hold_flags", {29'd0, bus4.cout, bus4.in_ready, bus4.out_valid}, 32'd1);
        end
        bus4.in_valid = 1'b0;
        consumeResult();
        checkOutput("t3_not_captured", bus4.sum, 32'h0000_0003);
        checkOutput("t3_idle", {30'd0, bus4.in_ready, bus4.busy}, 32'd2);

        // Reset in the middle of RUN
        applyStimulus(32'h0101_0101, 32'h0101_0101, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("t4_partial", bus4.sum, 32'h0000_0202);
        rst = 1'b1;
        #1;
        checkOutput("t4_rst_sum", bus4.sum, 32'h0000_0000);
        checkOutput("t4_rst_flags", {29'd0, bus4.out_valid, bus4.in_ready, bus4.busy}, 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t4_no_valid", {31'd0, bus4.out_valid}, 32'd0);
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
        waitResult(lat);
        checkOutput("t4_latency", lat,      32'd4);
        checkOutput("t4_sum",     bus4.sum, 32'h2345_6789);
        checkOutput("t4_cout",    {31'd0, bus4.cout}, 32'd0);
        consumeResult();

        // Back-to-back stream with both handshakes held high
        opA[0] = 32'h0000_0010; opB[0] = 32'h0000_0020; expSum[0] = 32'h0000_0030; expCout[0] = 1'b0;
        opA[1] = 32'h8000_0000; opB[1] = 32'h8000_0000; expSum[1] = 32'h0000_0000; expCout[1] = 1'b1;
        opA[2] = 32'h00AB_CDEF; opB[2] = 32'h0000_0011; expSum[2] = 32'h00AB_CE00; expCout[2] = 1'b0;
        nAcc = 0;
        nRes = 0;
        cyc  = 0;
        bus4.a = opA[0]; bus4.b = opB[0]; bus4.cin = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;
        while (nRes < 3 && cyc < 60) begin
            acc      = bus4.in_valid && bus4.in_ready;
            hs       = bus4.out_valid && bus4.out_ready;
            sumSnap  = bus4.sum;
            coutSnap = bus4.cout;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                if (nAcc < 3) accCyc[nAcc] = cyc;
                nAcc++;
                if (nAcc < 3) begin
                    bus4.a = opA[nAcc]; bus4.b = opB[nAcc];
                end else begin
                    bus4.in_valid = 1'b0;
                end
            end
            if (hs) begin
                if (nRes < 3) begin
                    checkOutput("t5_sum",  sumSnap, expSum[nRes]);
                    checkOutput("t5_cout", {31'd0, coutSnap}, {31'd0, expCout[nRes]});
                end
                nRes++;
            end
        end
        checkOutput("t5_results", nRes, 32'd3);
        checkOutput("t5_accepts", nAcc, 32'd3);
        checkOutput("t5_spacing01", accCyc[1] - accCyc[0], 32'd6);
        checkOutput("t5_spacing12", accCyc[2] - accCyc[1], 32'd6);
        sawExtra = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus4.out_valid) sawExtra = 1'b1;
        end
        checkOutput("t5_no_duplicate", {31'd0, sawExtra}, 32'd0);
        bus4.out_ready = 1'b0;

        // Single-word configuration
        bus1.a = 8'hF0; bus1.b = 8'h10; bus1.cin = 1'b0; bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("t6_latency", lat,      32'd1);
        checkOutput("t6_sum",     {24'd0, bus1.sum}, 32'h0000_0000);
        checkOutput("t6_cout",    {31'd0, bus1.cout}, 32'd1);
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        checkOutput("t6_after_hs", {30'd0, bus1.in_ready, bus1.out_valid}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
